// File: rtl/conv_window_streamer.sv
// conv_window_streamer: 3-row sliding-window reader for a stored 3-channel
// feature map (IMG_W x IMG_H). It issues BRAM reads, absorbs the 1-cycle
// read latency and streams one 3-pixel column per channel per beat.
// Ports: clk, rst (sync, active-low), start/busy/done frame control,
//   rd_addr_0..2 + rd_en / rd_data BRAM side,
//   col_r/g/b + out_valid/out_ready/out_sol/out_eof stream side.
// Optional macro CONV_STREAM_PERF_EN adds stall_cycles and beat_count.
module conv_window_streamer #(
    parameter int DATA_WIDTH = 22,
    parameter int IMG_W      = 222,
    parameter int IMG_H      = 222,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rd_addr_0,
    output logic [ADDR_WIDTH-1:0]   rd_addr_1,
    output logic [ADDR_WIDTH-1:0]   rd_addr_2,
    output logic                    rd_en,
    input  logic [9*DATA_WIDTH-1:0] rd_data,
    output logic [3*DATA_WIDTH-1:0] col_r,
    output logic [3*DATA_WIDTH-1:0] col_g,
    output logic [3*DATA_WIDTH-1:0] col_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sol,
    output logic                    out_eof
`ifdef CONV_STREAM_PERF_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             beat_count
`endif
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int EW = 9 * DW + 2;
    localparam logic [ADDR_WIDTH-1:0] ROW_A = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] LAST_A0 =
        ADDR_WIDTH'((IMG_H - 2) * IMG_W - 1);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   col;
    logic            inflight;
    logic            sol_d;
    logic            eof_d;
    logic [1:0]      count;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [EW-1:0]   fifo_q [2];
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;
    logic            start_ok;

    assign start_ok  = (state == S_IDLE) && start;
    assign push      = inflight;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign head      = fifo_q[rd_ptr];

    // Slot accounting counts this cycle's pop as freeing space, so a
    // steady out_ready keeps one read issued every cycle.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                busy  = 1'b1;
                rd_en = (count - 2'(pop) + 2'(inflight)) < 2'd2;
                if (rd_en && (rd_addr_0 == LAST_A0)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pop && out_eof) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Row addresses step by one per column; across a band boundary the
    // next band's row-k address is exactly the previous one plus one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rd_addr_0 <= '0;
            rd_addr_1 <= '0;
            rd_addr_2 <= '0;
            col       <= '0;
            inflight  <= 1'b0;
            sol_d     <= 1'b0;
            eof_d     <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            state    <= state_nx;
            inflight <= rd_en;
            if (start_ok) begin
                rd_addr_0 <= '0;
                rd_addr_1 <= ROW_A;
                rd_addr_2 <= ROW_A + ROW_A;
                col       <= '0;
            end else if (rd_en) begin
                rd_addr_0 <= rd_addr_0 + 1'b1;
                rd_addr_1 <= rd_addr_1 + 1'b1;
                rd_addr_2 <= rd_addr_2 + 1'b1;
                col       <= (col == LAST_C) ? '0 : col + 1'b1;
                sol_d     <= (col == '0);
                eof_d     <= (rd_addr_0 == LAST_A0);
            end
            if (push) begin
                fifo_q[wr_ptr] <= {sol_d, eof_d, rd_data};
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign col_r = {head[0*DW +: DW], head[1*DW +: DW], head[2*DW +: DW]};
    assign col_g = {head[3*DW +: DW], head[4*DW +: DW], head[5*DW +: DW]};
    assign col_b = {head[6*DW +: DW], head[7*DW +: DW], head[8*DW +: DW]};
    assign out_sol = out_valid && head[EW-1];
    assign out_eof = out_valid && head[EW-2];

`ifdef CONV_STREAM_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            beat_count   <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
            beat_count   <= '0;
        end else begin
            if (busy && out_valid && !out_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (pop && (beat_count != '1))
                beat_count <= beat_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_streamer.sv
// Testbench for conv_window_streamer: scoreboard of expected beats and
// read addresses built from the window-walk rules, checked by a monitor.
module tb_conv_window_streamer;

    localparam int DW = 22;
    localparam int W  = 4;
    localparam int H  = 5;
    localparam int AW = 18;
    localparam int NB = (H - 2) * W;

    typedef struct {
        logic [3*DW-1:0] r, g, b;
        logic            sol, eof;
        int              idx;
    } beat_t;

    typedef struct {
        logic [AW-1:0] a0, a1, a2;
    } addr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, rd_en, out_valid, out_sol, out_eof;
    logic            out_ready = 1'b1;
    logic [AW-1:0]   rd_addr_0, rd_addr_1, rd_addr_2;
    logic [9*DW-1:0] rd_data = '0;
    logic [3*DW-1:0] col_r, col_g, col_b;
`ifdef CONV_STREAM_PERF_EN
    logic [31:0]     stall_cycles, beat_count;
`endif

    conv_window_streamer #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_addr_2(rd_addr_2), .rd_en(rd_en), .rd_data(rd_data),
        .col_r(col_r), .col_g(col_g), .col_b(col_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sol(out_sol), .out_eof(out_eof)
`ifdef CONV_STREAM_PERF_EN
        , .stall_cycles(stall_cycles), .beat_count(beat_count)
`endif
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    beat_t sb_q[$];
    addr_t ad_q[$];
    int    issued_n = 0, accepted_n = 0, frame_acc = 0;
    int    done_seen = 0, cyc = 0;
    int    tb_stall = 0, tb_beats = 0;
    int    acc_cyc [NB];
    bit    exp_done = 0;
    bit    held = 0;
    logic [9*DW+1:0] held_pl;
    int    mode = 0;
    int    budget = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // BRAM model: channel c returns addr + 256*(c+1), one cycle late.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int ch = 0; ch < 3; ch++) begin
                rd_data[(3*ch+0)*DW +: DW] <= DW'(rd_addr_0) + DW'(256*(ch+1));
                rd_data[(3*ch+1)*DW +: DW] <= DW'(rd_addr_1) + DW'(256*(ch+1));
                rd_data[(3*ch+2)*DW +: DW] <= DW'(rd_addr_2) + DW'(256*(ch+1));
            end
        end
    end

    task automatic push_frame();
        beat_t bt;
        addr_t ad;
        logic [3*DW-1:0] v [3];
        int px;
        for (int b = 0; b <= H - 3; b++) begin
            for (int c = 0; c < W; c++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    v[ch] = '0;
                    for (int k = 0; k < 3; k++) begin
                        px = (b + k) * W + c + 256 * (ch + 1);
                        v[ch] = (v[ch] << DW) | (3*DW)'(px);
                    end
                end
                bt.r = v[0];
                bt.g = v[1];
                bt.b = v[2];
                bt.sol = (c == 0);
                bt.eof = (b == H - 3) && (c == W - 1);
                bt.idx = b * W + c;
                sb_q.push_back(bt);
                ad.a0 = AW'(b * W + c);
                ad.a1 = AW'((b + 1) * W + c);
                ad.a2 = AW'((b + 2) * W + c);
                ad_q.push_back(ad);
            end
        end
    endtask

    // Monitor: all checks on the falling edge, away from the active edge.
    always @(negedge clk) begin
        beat_t bt;
        addr_t ad;
        bit    p;
        cyc++;
        if (!rst) begin
            sb_q.delete();
            ad_q.delete();
            issued_n   = 0;
            accepted_n = 0;
            exp_done   = 0;
            held       = 0;
        end else begin
            p = out_valid && out_ready;
            if (start && !busy && !done) begin
                tb_stall  = 0;
                tb_beats  = 0;
                frame_acc = 0;
            end
            if (exp_done) begin
                chk("done_after_eof", {done, busy}, 2'b10);
                exp_done = 0;
                done_seen++;
            end else if (done) begin
                chk("spurious_done", done, 1'b0);
            end
            if (rd_en) begin
                chk("rd_slots", (issued_n - accepted_n - int'(p)) < 2, 1'b1);
                if (ad_q.size() == 0) begin
                    chk("extra_read", 1'b1, 1'b0);
                end else begin
                    ad = ad_q.pop_front();
                    chk("rd_addr", {rd_addr_0, rd_addr_1, rd_addr_2},
                        {ad.a0, ad.a1, ad.a2});
                end
            end
            if (held)
                chk("stall_stable", {col_r, col_g, col_b, out_sol, out_eof},
                    held_pl);
            if (busy && out_valid && !out_ready) tb_stall++;
            if (p) begin
                if (sb_q.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    bt = sb_q.pop_front();
                    chk("beat", {col_r, col_g, col_b, out_sol, out_eof},
                        {bt.r, bt.g, bt.b, bt.sol, bt.eof});
                    acc_cyc[bt.idx] = cyc;
                end
                if (out_eof) exp_done = 1;
                frame_acc++;
                tb_beats++;
            end
            held    = out_valid && !out_ready;
            held_pl = {col_r, col_g, col_b, out_sol, out_eof};
            issued_n   += int'(rd_en);
            accepted_n += int'(p);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = 1'b0;
                default: begin
                    if (out_valid && budget > 0) begin
                        out_ready = 1'b0;
                        budget--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        push_frame();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int d0;
        bit ok;
        d0 = done_seen;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_seen != d0) ok = 1;
        end
        chk("frame_done_timeout", ok, 1'b1);
        chk("frame_beats_left", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (frame_acc >= n) ok = 1;
        end
        chk("beat_wait_timeout", ok, 1'b1);
    endtask

    task automatic check_zero(input string name);
        chk(name, {busy, done, out_valid, rd_en, out_sol, out_eof,
                   rd_addr_0, rd_addr_1, rd_addr_2, col_r, col_g, col_b},
            '0);
    endtask

    initial begin
        cycles(3);
        check_zero("reset_state");
        rst = 1'b1;
        cycles(2);

        // Full-speed frame with latency checks.
        mode = 0;
        push_frame();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        chk("lat_c0_rd_en", rd_en, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_c1", {rd_en, out_valid, busy}, 3'b101);
        @(negedge clk);
        chk("lat_c2_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_c3_valid", out_valid, 1'b1);
        wait_done(100);
        chk("throughput", 32'(acc_cyc[NB-1] - acc_cyc[0]), 32'(NB - 1));
`ifdef CONV_STREAM_PERF_EN
        chk("perf_beats_fast", beat_count, 32'(NB));
        chk("perf_stall_fast", stall_cycles, 32'd0);
`endif
        cycles(3);

        // Random backpressure frames.
        mode = 1;
        for (int f = 0; f < 3; f++) begin
            do_start();
            wait_done(400);
`ifdef CONV_STREAM_PERF_EN
            chk("perf_stall_rand", stall_cycles, 32'(tb_stall));
            chk("perf_beats_rand", beat_count, 32'(tb_beats));
`endif
            cycles(2);
        end

        // Consumer held off for 10 cycles after start.
        mode = 2;
        do_start();
        cycles(9);
        chk("hold_reads", 32'(issued_n - accepted_n), 32'd2);
        chk("hold_valid", {out_valid, out_sol}, 2'b11);
        chk("hold_head", col_r, sb_q[0].r);
        mode = 0;
        wait_done(100);
        cycles(2);

        // Second start mid-frame is ignored.
        mode = 1;
        do_start();
        wait_acc(6);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_done(400);
        cycles(10);
        chk("no_restart", {out_valid, busy, 32'(sb_q.size())}, '0);

        // Reset mid-frame, then a clean frame from address 0.
        do_start();
        wait_acc(6);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        check_zero("mid_reset");
        cycles(20);
        chk("post_reset_idle", {busy, out_valid}, 2'b00);
        mode = 0;
        do_start();
        wait_done(100);
        cycles(2);

        // Exactly seven stall cycles.
        mode = 3;
        budget = 7;
        do_start();
        wait_done(200);
`ifdef CONV_STREAM_PERF_EN
        cycles(3);
        chk("perf_stall7", stall_cycles, 32'd7);
        chk("perf_beats12", beat_count, 32'(NB));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
